xpmwrap_tdpram_arb: RTL and testbench

XPMWRAP_TDPRAM_ARB -- requirements
Module: xpmwrap_tdpram_arb

---
 rtl/xpmwrap_pkg.sv | 12 +
 rtl/xpmwrap_rr_arb.sv | 50 +++++
 rtl/xpmwrap_tdpram_arb.sv | 99 +++++++++
 tb/tb_xpmwrap_tdpram_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xpmwrap_pkg.sv
// Shared constants and the round-robin pointer helper for the TDP RAM port-A arbiter.
// Optional feature macro used by the top: XPMWRAP_TDPRAM_ARB_STATS_EN.
package xpmwrap_pkg;

    localparam int STAT_WIDTH = 16;

    // Pointer moves to the slot just after the winner, wrapping at num.
    function automatic int rr_next(input int idx, input int num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xpmwrap_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant from req_valid and a registered priority pointer.
module xpmwrap_rr_arb
    import xpmwrap_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_idx
);

    logic [IDW-1:0] ptr;
    logic           found;
    int             idx;

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    // Reset blocks any grant so nothing reaches the RAM while it is held.
    always_comb begin
        grant_valid = found & rst_n;
        grant       = '0;
        if (grant_valid) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= IDW'(rr_next(int'(grant_idx), NUM_REQ));
        end
    end

endmodule

// File: rtl/xpmwrap_tdpram_arb.sv
// Arbitrates NUM_REQ requesters onto TDP RAM port A and returns read data tagged with requester id.
// Optional per-requester grant counters are built when XPMWRAP_TDPRAM_ARB_STATS_EN is defined.
module xpmwrap_tdpram_arb
    import xpmwrap_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clka,
    input  logic                          rsta_n,
    // A request transfers in the cycle req_valid[i] & req_ready[i]; responses have no backpressure.
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_ena,
    output logic                          ram_wea,
    output logic                          ram_regcea,
    output logic [ADDR_WIDTH-1:0]         ram_addra,
    output logic [DATA_WIDTH-1:0]         ram_dina,
    input  logic [DATA_WIDTH-1:0]         ram_douta
`ifdef XPMWRAP_TDPRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_WIDTH-1:0] stat_grants
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDW-1:0]     grant_idx;
    logic               rd_issue;

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [IDW-1:0]          id_pipe [READ_LATENCY];

    xpmwrap_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .clk         (clka),
        .rst_n       (rsta_n),
        .req_valid   (req_valid),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        req_ready  = grant;
        ram_ena    = grant_valid;
        ram_wea    = grant_valid & req_we[grant_idx];
        ram_regcea = 1'b1;
        ram_addra  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ram_dina   = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        rd_issue   = grant_valid & ~req_we[grant_idx];
    end

    // Tag pipeline matches the RAM read latency so the id lines up with ram_douta.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) id_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd_issue;
            id_pipe[0]  <= grant_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign rsp_valid = vld_pipe[READ_LATENCY-1];
    assign rsp_id    = id_pipe[READ_LATENCY-1];
    assign rsp_rdata = ram_douta;

`ifdef XPMWRAP_TDPRAM_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [STAT_WIDTH-1:0] cnt;
        always_ff @(posedge clka or negedge rsta_n) begin
            if (!rsta_n) begin
                cnt <= '0;
            end else if (grant[g] && cnt != {STAT_WIDTH{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
        assign stat_grants[g*STAT_WIDTH +: STAT_WIDTH] = cnt;
    end
`endif

endmodule

// File: tb/tb_xpmwrap_tdpram_arb.sv
// Directed bench for xpmwrap_tdpram_arb with a behavioural 2-cycle RAM on port A.
module tb_xpmwrap_tdpram_arb;

    localparam int NR = 4;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int RL = 2;

    logic              clka;
    logic              rsta_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_rdata;
    logic              ram_ena;
    logic              ram_wea;
    logic              ram_regcea;
    logic [AW-1:0]     ram_addra;
    logic [DW-1:0]     ram_dina;
    logic [DW-1:0]     ram_douta;
`ifdef XPMWRAP_TDPRAM_ARB_STATS_EN
    logic [NR*16-1:0]  stat_grants;
`endif

    xpmwrap_tdpram_arb #(
        .NUM_REQ      (NR),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clka       (clka),
        .rsta_n     (rsta_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .ram_ena    (ram_ena),
        .ram_wea    (ram_wea),
        .ram_regcea (ram_regcea),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_douta  (ram_douta)
`ifdef XPMWRAP_TDPRAM_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    // clock / reset block
    initial clka = 1'b0;
    always #5 clka = ~clka;

    // behavioural RAM, port A, two register stages on the read path
    logic [DW-1:0] mem [64];
    logic [DW-1:0] rd_s1, rd_s2;
    always_ff @(posedge clka) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
        if (ram_ena && !ram_wea) rd_s1 <= mem[ram_addra];
        rd_s2 <= rd_s1;
    end
    assign ram_douta = rd_s2;

    // scoreboard: {due cycle[65:34], id[33:32], data[31:0]}
    logic [65:0]   exp_q[$];
    logic [DW-1:0] shadow [64];
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [NR-1:0] v;
        logic [NR-1:0] we;
        logic [NR-1:0] rdy;
    } vec_t;
    vec_t tab[17];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NR*AW-1:0] pack_a(input int k);
        logic [NR*AW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*AW +: AW] = AW'((i * 4 + k) % 16);
        return r;
    endfunction

    function automatic logic [NR*DW-1:0] pack_d(input int k);
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = {8'h50 + 8'(i), 8'(k), 16'h1234};
        return r;
    endfunction

    task automatic check_rsp();
        logic [65:0] e;
        if (exp_q.size() > 0 && int'(exp_q[0][65:34]) == cyc) begin
            e = exp_q.pop_front();
            cmp("rsp_valid", 64'(rsp_valid), 64'd1);
            cmp("rsp_id", 64'(rsp_id), 64'(e[33:32]));
            cmp("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        end else begin
            cmp("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        end
    endtask

    // driver: one cycle of requests, checks grant, RAM controls and response
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] we,
                        input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d,
                        input logic [NR-1:0] exp_rdy);
        int g;
        logic [AW-1:0] ea;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clka);
        check_rsp();
        cmp("req_ready", 64'(req_ready), 64'(exp_rdy));
        cmp("ram_regcea", 64'(ram_regcea), 64'd1);
        g = -1;
        for (int i = 0; i < NR; i++) if (exp_rdy[i]) g = i;
        if (g >= 0) begin
            ea = a[g*AW +: AW];
            cmp("ram_ena", 64'(ram_ena), 64'd1);
            cmp("ram_wea", 64'(ram_wea), 64'(we[g]));
            cmp("ram_addra", 64'(ram_addra), 64'(ea));
            if (we[g]) begin
                cmp("ram_dina", 64'(ram_dina), 64'(d[g*DW +: DW]));
                shadow[ea] = d[g*DW +: DW];
            end else begin
                exp_q.push_back({32'(cyc + RL), 2'(g), shadow[ea]});
            end
        end else begin
            cmp("ram_ena_idle", 64'(ram_ena), 64'd0);
            cmp("ram_wea_idle", 64'(ram_wea), 64'd0);
        end
        @(posedge clka);
        #1;
        cyc++;
    endtask

    initial begin
        logic [NR*AW-1:0] a;
        logic [NR*DW-1:0] d;

        // arbitration table; pointer is 1 after the fill phase below
        tab[0]  = '{4'b1111, 4'b0000, 4'b0010};
        tab[1]  = '{4'b1111, 4'b0000, 4'b0100};
        tab[2]  = '{4'b1111, 4'b0000, 4'b1000};
        tab[3]  = '{4'b1111, 4'b0000, 4'b0001};
        tab[4]  = '{4'b1111, 4'b0000, 4'b0010};
        tab[5]  = '{4'b1111, 4'b0000, 4'b0100};
        tab[6]  = '{4'b1111, 4'b0000, 4'b1000};
        tab[7]  = '{4'b0000, 4'b0000, 4'b0000};
        tab[8]  = '{4'b1010, 4'b0000, 4'b0010};
        tab[9]  = '{4'b1010, 4'b0000, 4'b1000};
        tab[10] = '{4'b0001, 4'b0001, 4'b0001};
        tab[11] = '{4'b0011, 4'b0001, 4'b0010};
        tab[12] = '{4'b0011, 4'b0001, 4'b0001};
        tab[13] = '{4'b0011, 4'b0010, 4'b0010};
        tab[14] = '{4'b0011, 4'b0010, 4'b0001};
        tab[15] = '{4'b0101, 4'b0000, 4'b0100};
        tab[16] = '{4'b1000, 4'b0000, 4'b1000};

        rsta_n    = 1'b0;
        req_valid = '1;
        req_we    = '1;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        cmp("reset_req_ready", 64'(req_ready), 64'd0);
        cmp("reset_ram_ena", 64'(ram_ena), 64'd0);
        cmp("reset_ram_wea", 64'(ram_wea), 64'd0);
        cmp("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        req_valid = '0;
        rsta_n    = 1'b1;
        @(posedge clka);
        #1;

        // fill addresses 0..15 through requester 0 (sole requester, no bubbles)
        for (int k = 0; k < 16; k++) begin
            a = '0;
            d = '0;
            a[0 +: AW] = AW'(k);
            d[0 +: DW] = 32'hC0DE_0000 + 32'(k);
            step(4'b0001, 4'b0001, a, d, 4'b0001);
        end

        for (int k = 0; k < 17; k++)
            step(tab[k].v, tab[k].we, pack_a(k), pack_d(k), tab[k].rdy);

        // only requester 3 valid for 10 reads
        for (int k = 0; k < 10; k++)
            step(4'b1000, 4'b0000, pack_a(k + 20), pack_d(k + 20), 4'b1000);
        repeat (3) step(4'b0000, 4'b0000, '0, '0, 4'b0000);

        // req 0 writes DEADBEEF to 5, req 2 reads it back
        a = '0;
        d = '0;
        a[0 +: AW] = 6'd5;
        d[0 +: DW] = 32'hDEADBEEF;
        step(4'b0001, 4'b0001, a, d, 4'b0001);
        a = '0;
        a[2*AW +: AW] = 6'd5;
        step(4'b0100, 4'b0000, a, '0, 4'b0100);
        repeat (3) step(4'b0000, 4'b0000, '0, '0, 4'b0000);

        // two reads in flight, then reset; both must be dropped
        step(4'b0011, 4'b0000, pack_a(40), pack_d(40), 4'b0001);
        step(4'b0011, 4'b0000, pack_a(41), pack_d(41), 4'b0010);
        rsta_n = 1'b0;
        #1;
        cmp("rst_mid_req_ready", 64'(req_ready), 64'd0);
        cmp("rst_mid_ram_ena", 64'(ram_ena), 64'd0);
        cmp("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        exp_q.delete();
        req_valid = '0;
        @(posedge clka);
        @(negedge clka);
        rsta_n = 1'b1;
        @(posedge clka);
        #1;
        cyc = cyc + 2;
        repeat (4) step(4'b0000, 4'b0000, '0, '0, 4'b0000);
        step(4'b1010, 4'b0000, pack_a(50), pack_d(50), 4'b0010);
        repeat (3) step(4'b0000, 4'b0000, '0, '0, 4'b0000);
        cmp("queue_drained", 64'(exp_q.size()), 64'd0);

`ifdef XPMWRAP_TDPRAM_ARB_STATS_EN
        rsta_n = 1'b0;
        @(negedge clka);
        rsta_n    = 1'b1;
        req_we    = 4'b0010;
        req_valid = 4'b0010;
        repeat (70000) @(posedge clka);
        #1;
        req_valid = '0;
        @(negedge clka);
        cmp("stat_grants0", 64'(stat_grants[0 +: 16]), 64'h0);
        cmp("stat_grants1", 64'(stat_grants[16 +: 16]), 64'hFFFF);
        cmp("stat_grants2", 64'(stat_grants[32 +: 16]), 64'h0);
        cmp("stat_grants3", 64'(stat_grants[48 +: 16]), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
